count_seq_checker: RTL and testbench

Consumer-side sequence checker for the output of a wrapping up-counter. Samples a count value on every valid cycle, predicts the next value (increment by one, wrap to 0 after `MAX`), and flags every skip, repeat, early wrap or out-of-range value. Sits downstream of the counter in system builds and benches, and provides the runtime counterpart to the counter's formal no-skip property: error pulse, sticky flag, saturating error count and first-error capture.

---
 rtl/count_seq_checker.sv | 163 ++++++++++++++++
 tb/tb_count_seq_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// -----------------------------------------------------------------------------
// count_seq_checker
//
// Consumer-side sequence checker for a wrapping up-counter. Every accepted
// sample is compared with the value predicted from the previous one
// (increment by one, wrap to 0 after MAX). Mismatches give a one-cycle error
// pulse, a sticky flag, a saturating error count and a capture of the first
// expected/received pair. After each mismatch the checker re-syncs to the
// received value, so one glitch costs one error rather than a cascade.
//
// Parameters
//   WIDTH  width of the checked count
//   MAX    last count value before wrap to 0 (1 .. 2**WIDTH-1)
//   ERR_W  width of the error counter
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   en          in   check enable; low holds all state and ignores samples
//   clear       in   synchronous soft clear of sync state and error records
//   in_valid    in   in_count is valid this cycle
//   in_count    in   sampled counter value
//   synced      out  a reference sample is held and checking is active
//   exp_count   out  value expected on the next valid sample (0 if unsynced)
//   err_pulse   out  one-cycle pulse per mismatching sample
//   err_sticky  out  set on first mismatch, held until clear/reset
//   err_count   out  mismatch count, saturating at all-ones
//   first_exp   out  expected value at the first mismatch
//   first_got   out  received value at the first mismatch
// -----------------------------------------------------------------------------
module count_seq_checker #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             synced,
    output logic [WIDTH-1:0] exp_count,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_got_q, first_got_d;

    logic             accept;
    logic             in_range;
    logic [WIDTH-1:0] exp_w;

    assign accept   = en && in_valid && !clear;
    assign in_range = (in_count <= MAX_V);
    // Prediction from the held reference; the explicit wrap compare keeps
    // this correct when MAX is below the natural WIDTH-bit rollover.
    assign exp_w    = (prev_q == MAX_V) ? '0 : prev_q + WIDTH'(1);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state_q      <= UNSYNC;
            prev_q       <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            first_exp_q  <= '0;
            first_got_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            first_exp_q  <= first_exp_d;
            first_got_q  <= first_got_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every target gets a hold/default value first, so no path
        // through the branches below can leave one unassigned (no latches).
        state_d      = state_q;
        prev_d       = prev_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        first_exp_d  = first_exp_q;
        first_got_d  = first_got_q;

        if (clear) begin
            state_d      = UNSYNC;
            prev_d       = '0;
            err_sticky_d = 1'b0;
            err_count_d  = '0;
            first_exp_d  = '0;
            first_got_d  = '0;
        end else if (accept) begin
            unique case (state_q)
                UNSYNC: begin
                    // An out-of-range value cannot serve as a reference.
                    if (in_range) begin
                        prev_d  = in_count;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (in_count != exp_w) begin
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (!err_sticky_q) begin
                            first_exp_d = exp_w;
                            first_got_d = in_count;
                        end
                    end
                    // Re-sync to whatever arrived; an illegal value drops
                    // back to UNSYNC so the next sample becomes the reference.
                    if (in_range) begin
                        prev_d = in_count;
                    end else begin
                        state_d = UNSYNC;
                    end
                end
                default: state_d = UNSYNC;
            endcase
        end
    end

    // Output logic (registers only, no input-to-output path)
    always_comb begin
        synced     = (state_q == TRACK);
        exp_count  = (state_q == TRACK) ? exp_w : '0;
        err_pulse  = err_pulse_q;
        err_sticky = err_sticky_q;
        err_count  = err_count_q;
        first_exp  = first_exp_q;
        first_got  = first_got_q;
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_count_seq_checker
//
// Two checker instances share one stimulus stream: A uses the defaults
// (WIDTH 4, MAX 15, ERR_W 8), B uses MAX 9 and ERR_W 2 to reach the
// out-of-range and saturation cases. A behavioural model predicts each
// instance's outputs; predictions are queued when a step is driven and
// popped for comparison one edge later. Directed constant checks back up
// the headline values of each scenario.
// -----------------------------------------------------------------------------
module tb_count_seq_checker;

    typedef struct {
        bit track;
        int prev;
        bit pulse;
        bit sticky;
        int cnt;
        int fe;
        int fg;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_count = '0;

    logic       a_synced, a_err_pulse, a_err_sticky;
    logic [3:0] a_exp_count, a_first_exp, a_first_got;
    logic [7:0] a_err_count;

    logic       b_synced, b_err_pulse, b_err_sticky;
    logic [3:0] b_exp_count, b_first_exp, b_first_got;
    logic [1:0] b_err_count;

    int n_pass  = 0;
    int n_total = 0;

    mstate_t ma, mb;
    mstate_t sb_a[$];
    mstate_t sb_b[$];

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(4), .MAX(15), .ERR_W(8)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_count   (in_count),
        .synced     (a_synced),
        .exp_count  (a_exp_count),
        .err_pulse  (a_err_pulse),
        .err_sticky (a_err_sticky),
        .err_count  (a_err_count),
        .first_exp  (a_first_exp),
        .first_got  (a_first_got)
    );

    count_seq_checker #(.WIDTH(4), .MAX(9), .ERR_W(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_count   (in_count),
        .synced     (b_synced),
        .exp_count  (b_exp_count),
        .err_pulse  (b_err_pulse),
        .err_sticky (b_err_sticky),
        .err_count  (b_err_count),
        .first_exp  (b_first_exp),
        .first_got  (b_first_got)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference behaviour of one checker instance for one clock edge.
    function automatic mstate_t model_next(input mstate_t s, input int max_v, input int cnt_max,
                                           input bit r, input bit e, input bit c,
                                           input bit v, input int smp);
        mstate_t n;
        int      nxt;
        n = s;
        n.pulse = 1'b0;
        if (!r) begin
            n = '{track: 0, prev: 0, pulse: 0, sticky: 0, cnt: 0, fe: 0, fg: 0};
            return n;
        end
        if (c) begin
            n = '{track: 0, prev: 0, pulse: 0, sticky: 0, cnt: 0, fe: 0, fg: 0};
            return n;
        end
        if (!(e && v)) return n;
        if (!s.track) begin
            if (smp <= max_v) begin
                n.track = 1'b1;
                n.prev  = smp;
            end
            return n;
        end
        nxt = (s.prev + 1) % (max_v + 1);
        if (smp != nxt) begin
            n.pulse  = 1'b1;
            n.cnt    = (s.cnt < cnt_max) ? s.cnt + 1 : cnt_max;
            n.sticky = 1'b1;
            if (!s.sticky) begin
                n.fe = nxt;
                n.fg = smp;
            end
        end
        n.prev = smp;
        if (smp > max_v) n.track = 1'b0;
        return n;
    endfunction

    task automatic cmp(input string who, input mstate_t e, input int max_v,
                       input logic syn, input logic [31:0] expc, input logic pul,
                       input logic sti, input logic [31:0] cnt,
                       input logic [31:0] fe, input logic [31:0] fg);
        check({who, ".synced"},     {31'd0, syn}, {31'd0, e.track});
        check({who, ".exp_count"},  expc, e.track ? 32'((e.prev + 1) % (max_v + 1)) : 32'd0);
        check({who, ".err_pulse"},  {31'd0, pul}, {31'd0, e.pulse});
        check({who, ".err_sticky"}, {31'd0, sti}, {31'd0, e.sticky});
        check({who, ".err_count"},  cnt, 32'(e.cnt));
        check({who, ".first_exp"},  fe, 32'(e.fe));
        check({who, ".first_got"},  fg, 32'(e.fg));
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit v, input int smp);
        mstate_t na, nb;
        na = model_next(ma, 15, 255, r, e, c, v, smp);
        nb = model_next(mb, 9, 3, r, e, c, v, smp);
        sb_a.push_back(na);
        sb_b.push_back(nb);
        ma = na;
        mb = nb;
        rst_n    = r;
        en       = e;
        clear    = c;
        in_valid = v;
        in_count = 4'(smp);
        @(posedge clk);
        #1;
        cmp("A", sb_a.pop_front(), 15, a_synced, 32'(a_exp_count), a_err_pulse, a_err_sticky,
            32'(a_err_count), 32'(a_first_exp), 32'(a_first_got));
        cmp("B", sb_b.pop_front(), 9, b_synced, 32'(b_exp_count), b_err_pulse, b_err_sticky,
            32'(b_err_count), 32'(b_first_exp), 32'(b_first_got));
    endtask

    task automatic sample(input int v);
        step(1'b1, 1'b1, 1'b0, 1'b1, v);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, ".synced"},    {31'd0, a_synced}, 32'd0);
        check({tag, ".exp_count"}, 32'(a_exp_count), 32'd0);
        check({tag, ".err_pulse"}, {31'd0, a_err_pulse}, 32'd0);
        check({tag, ".sticky"},    {31'd0, a_err_sticky}, 32'd0);
        check({tag, ".err_count"}, 32'(a_err_count), 32'd0);
        check({tag, ".first_exp"}, 32'(a_first_exp), 32'd0);
        check({tag, ".first_got"}, 32'(a_first_got), 32'd0);
    endtask

    initial begin
        ma = '{track: 0, prev: 0, pulse: 0, sticky: 0, cnt: 0, fe: 0, fg: 0};
        mb = ma;

        // Reset state
        do_reset();
        check_all_zero_a("reset");

        // Clean wrap 3..15,0,1,2 on A
        for (int v = 3; v <= 15; v++) sample(v);
        sample(0);
        sample(1);
        sample(2);
        check("wrap.synced",    {31'd0, a_synced}, 32'd1);
        check("wrap.exp_count", 32'(a_exp_count), 32'd3);
        check("wrap.err_count", 32'(a_err_count), 32'd0);
        check("wrap.sticky",    {31'd0, a_err_sticky}, 32'd0);

        // Early wrap at 14 on A
        do_reset();
        sample(12);
        sample(13);
        sample(14);
        sample(0);
        check("early.pulse",     {31'd0, a_err_pulse}, 32'd1);
        check("early.err_count", 32'(a_err_count), 32'd1);
        check("early.first_exp", 32'(a_first_exp), 32'd15);
        check("early.first_got", 32'(a_first_got), 32'd0);
        sample(1);
        check("early.clean_pulse", {31'd0, a_err_pulse}, 32'd0);
        check("early.clean_count", 32'(a_err_count), 32'd1);

        // Skip, repeat and out-of-range on B (MAX 9)
        do_reset();
        sample(5);
        sample(7);
        sample(7);
        sample(12);
        check("oor.unsync", {31'd0, b_synced}, 32'd0);
        sample(3);
        check("oor.err_count", 32'(b_err_count), 32'd3);
        check("oor.first_exp", 32'(b_first_exp), 32'd6);
        check("oor.first_got", 32'(b_first_got), 32'd7);
        check("oor.resync",    {31'd0, b_synced}, 32'd1);
        check("oor.pulse",     {31'd0, b_err_pulse}, 32'd0);
        check("oor.exp_count", 32'(b_exp_count), 32'd4);

        // Gaps and enable on A
        do_reset();
        sample(4);
        for (int i = 0; i < 5; i++) idle();
        sample(5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 9);
        sample(6);
        check("gap.err_count", 32'(a_err_count), 32'd0);
        check("gap.exp_count", 32'(a_exp_count), 32'd7);

        // Clear together with a mismatch
        do_reset();
        sample(2);
        sample(5);
        check("clr.pre_count", 32'(a_err_count), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 9);
        check_all_zero_a("clr");

        // Reset the edge after a mismatch
        sample(2);
        sample(3);
        sample(7);
        check("rst.pre_pulse", {31'd0, a_err_pulse}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8);
        check_all_zero_a("rst_after");

        // Reset on the same edge as a mismatch
        step(1'b1, 1'b1, 1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 9);
        check_all_zero_a("rst_same");

        // Saturation on B (ERR_W 2)
        do_reset();
        sample(1);
        for (int i = 0; i < 5; i++) begin
            sample(1);
            check("sat.pulse", {31'd0, b_err_pulse}, 32'd1);
            check("sat.count", 32'(b_err_count), 32'(sat_exp[i]));
        end
        idle();
        check("sat.pulse_end", {31'd0, b_err_pulse}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
